sdram_arbiter_n: RTL
====================

SDRAM_ARBITER_N -- requirements
Module: sdram_arbiter_n

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of bus masters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 26, SDRAM word-address width.
REQ-003 SHALL have parameter RR_MODE, default 0, with 0 = fixed priority (index 0 highest) and 1 = round-robin.
REQ-004 SHALL have parameter STARVE_LIMIT, default 64, the number of ready cycles a request may wait before promotion (0 disables promotion).
REQ-005 SHALL have localparam ID_W = clog2(NUM_MASTERS+1); master ID k+1 denotes port index k, and ID 0 denotes idle.
REQ-006 SHALL have port: clock  in  1  system clock.
REQ-007 SHALL have port: reset  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port: m_request  in  NUM_MASTERS  per-master request.
REQ-009 SHALL have port: m_write  in  NUM_MASTERS  per-master write flag.
REQ-010 SHALL have port: m_burst  in  NUM_MASTERS  per-master burst flag.
REQ-011 SHALL have port: m_address  in  NUM_MASTERS*ADDR_W  flattened addresses, master k at [k*ADDR_W +: ADDR_W].
REQ-012 SHALL have port: m_wdata  in  NUM_MASTERS*32  flattened write data.
REQ-013 SHALL have port: m_byte_en  in  NUM_MASTERS*4  flattened byte enables.
REQ-014 SHALL have port: m_ack  out  NUM_MASTERS  one-hot request-accept pulse.
REQ-015 SHALL have port: m_valid  out  NUM_MASTERS  read-data-valid strobe per master.
REQ-016 SHALL have port: m_complete  out  NUM_MASTERS  transaction-complete strobe per master.
REQ-017 SHALL have port: m_rdata  out  32  shared read data.
REQ-018 SHALL have ports sdram_request, sdram_write, sdram_burst (out, 1), sdram_address (out, ADDR_W), sdram_wdata (out, 32), sdram_byte_en (out, 4) and sdram_master (out, ID_W), all registered.
REQ-019 SHALL have ports sdram_ready (in, 1), sdram_rdata (in, 32), and sdram_valid and sdram_complete (in, ID_W), the latter two carrying the returning master ID.

Function
REQ-020 SHALL arbitrate only in cycles where sdram_ready=1; when sdram_ready=0, next grant SHALL equal the current master and all registered outputs SHALL hold.
REQ-021 SHALL assert m_ack[k] combinationally when sdram_ready=1 and master k is granted, including in the same cycle the request first appears.
REQ-022 SHALL, on a grant at the clock edge, load sdram_request=1, sdram_master=k+1 and master k's write, burst, address, wdata and byte_en.
REQ-023 SHALL, when sdram_ready=1 with no requests, load sdram_request=0 and sdram_master=0; the other sdram_* outputs are don't-care.
REQ-024 SHALL, when RR_MODE=0, grant the lowest-index requester.
REQ-025 SHALL, when RR_MODE=1, search from (last_granted+1) mod NUM_MASTERS upward with wrap-around; last_granted SHALL update only on a grant and SHALL be unchanged by idle cycles.
REQ-026 SHALL keep a wait counter per master that increments, saturating at STARVE_LIMIT, in each sdram_ready cycle where that master requests and is not granted, and clears on grant or when its request drops.
REQ-027 SHALL give starved masters (counter == STARVE_LIMIT) absolute precedence over the REQ-024/025 ordering, choosing the lowest index among them.
REQ-028 SHALL drive m_valid[k] = (sdram_valid == k+1) and m_complete[k] = (sdram_complete == k+1); an ID of 0 or greater than NUM_MASTERS SHALL assert no bit.
REQ-029 SHALL drive m_rdata = sdram_rdata when any m_valid bit is set, and 0 otherwise.
REQ-030 SHALL keep m_ack, m_valid and m_complete one-hot or zero at all times.
REQ-031 SHALL allow a new request to be granted in the same cycle that another master's read data is returning; returns SHALL be routed purely by ID and are independent of the current grant.

Reset
REQ-032 SHALL, on reset, clear sdram_request, sdram_master, all wait counters and last_granted (to NUM_MASTERS-1, so master 0 is searched first).
REQ-033 SHALL force m_ack=0 while reset is asserted; a reset mid-transaction SHALL abandon grant state, and in-flight returns SHALL still be routed by REQ-028.

Structure
REQ-034 SHALL take ID_W and the idle ID constant (0) from the shared memory-system package.
REQ-035 SHALL use one sub-module, prio_pick, a parameterised rotate-and-priority-encode from a request vector and start index to a one-hot grant, instantiated for both normal and starved selection.

Verification
REQ-036 SHALL test fixed priority: RR_MODE=0, requests 4'b1010 with ready=1 -> m_ack=4'b0010, sdram_master=2 next cycle.
REQ-037 SHALL test round-robin: RR_MODE=1 with all four requesting continuously and ready=1 -> grant sequence 1,2,3,4,1 on sdram_master.
REQ-038 SHALL test the stall: ready=0 for 5 cycles with new requests -> m_ack=0 and sdram_* unchanged, then a grant on the first ready=1 cycle.
REQ-039 SHALL test starvation: RR_MODE=0, STARVE_LIMIT=4, master 0 always requesting and master 3 requesting -> master 3 granted on its 5th ready cycle.
REQ-040 SHALL test return routing: sdram_valid=3 with sdram_rdata=32'hDEADBEEF -> m_valid=4'b0100, m_rdata=DEADBEEF; sdram_valid=7 -> m_valid=0, m_rdata=0.
REQ-041 SHALL test reset: reset asserted mid-grant -> sdram_request=0 and sdram_master=0 next cycle, and m_ack=0 throughout reset.

Source files
------------

// File: rtl/sdram_arbiter_n_pkg.sv
// Shared memory-system definitions: master-ID sizing and the idle ID.
package sdram_arbiter_n_pkg;

  localparam int unsigned IDLE_ID = 0;

  // One extra code point so that ID 0 can mean "no master".
  function automatic int unsigned id_width(int unsigned num_masters);
    return $clog2(num_masters + 1);
  endfunction

endpackage

// File: rtl/sdram_arbiter_n_prio_pick.sv
// Rotating priority encoder: first set request at or after start (with wrap) wins, one-hot out.
module sdram_arbiter_n_prio_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     request,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     grant
);

  // Walk from the farthest offset back to start so the nearest requester is written last.
  always_comb begin
    grant = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (request[IDX_W'((int'(start) + i) % int'(N))]) begin
        grant = '0;
        grant[IDX_W'((int'(start) + i) % int'(N))] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter_n.sv
// N-master SDRAM front-end arbiter: fixed or round-robin priority with starvation promotion,
// registered command outputs and ID-routed read/complete returns.
module sdram_arbiter_n
  import sdram_arbiter_n_pkg::*;
#(
  parameter int unsigned NUM_MASTERS  = 4,
  parameter int unsigned ADDR_W       = 26,
  parameter int unsigned RR_MODE      = 0,
  parameter int unsigned STARVE_LIMIT = 64,
  localparam int unsigned ID_W = id_width(NUM_MASTERS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_MASTERS-1:0]      m_request,
  input  logic [NUM_MASTERS-1:0]      m_write,
  input  logic [NUM_MASTERS-1:0]      m_burst,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
  input  logic [NUM_MASTERS*32-1:0]   m_wdata,
  input  logic [NUM_MASTERS*4-1:0]    m_byte_en,
  output logic [NUM_MASTERS-1:0]      m_ack,
  output logic [NUM_MASTERS-1:0]      m_valid,
  output logic [NUM_MASTERS-1:0]      m_complete,
  output logic [31:0]                 m_rdata,
  output logic                        sdram_request,
  output logic                        sdram_write,
  output logic                        sdram_burst,
  output logic [ADDR_W-1:0]           sdram_address,
  output logic [31:0]                 sdram_wdata,
  output logic [3:0]                  sdram_byte_en,
  output logic [ID_W-1:0]             sdram_master,
  input  logic                        sdram_ready,
  input  logic [31:0]                 sdram_rdata,
  input  logic [ID_W-1:0]             sdram_valid,
  input  logic [ID_W-1:0]             sdram_complete
);

  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

  logic [IDX_W-1:0]       last_q, rr_start, grant_idx;
  logic [CNT_W-1:0]       wait_q [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] starved, norm_grant, starve_grant, grant;
  logic [ID_W-1:0]        grant_id;
  logic                   pick_write, pick_burst;
  logic [ADDR_W-1:0]      pick_address;
  logic [31:0]            pick_wdata;
  logic [3:0]             pick_byte_en;

  assign rr_start = (RR_MODE == 0) ? '0 :
                    (last_q == LAST_IDX) ? '0 : last_q + 1'b1;

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_starve
    assign starved[k] = (STARVE_LIMIT != 0) && m_request[k] &&
                        (wait_q[k] == CNT_W'(STARVE_LIMIT));
  end

  sdram_arbiter_n_prio_pick #(.N(NUM_MASTERS)) u_pick_norm (
    .request (m_request),
    .start   (rr_start),
    .grant   (norm_grant)
  );

  sdram_arbiter_n_prio_pick #(.N(NUM_MASTERS)) u_pick_starve (
    .request (starved),
    .start   ('0),
    .grant   (starve_grant)
  );

  assign grant = (|starved) ? starve_grant : norm_grant;
  assign m_ack = (sdram_ready && !reset) ? grant : '0;

  always_comb begin
    grant_idx    = '0;
    pick_write   = 1'b0;
    pick_burst   = 1'b0;
    pick_address = '0;
    pick_wdata   = '0;
    pick_byte_en = '0;
    for (int k = 0; k < int'(NUM_MASTERS); k++) begin
      if (grant[k]) begin
        grant_idx    = IDX_W'(k);
        pick_write   = m_write[k];
        pick_burst   = m_burst[k];
        pick_address = m_address[k*ADDR_W +: ADDR_W];
        pick_wdata   = m_wdata[k*32 +: 32];
        pick_byte_en = m_byte_en[k*4 +: 4];
      end
    end
  end

  assign grant_id = ID_W'(grant_idx) + ID_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      sdram_request <= 1'b0;
      sdram_master  <= ID_W'(IDLE_ID);
      last_q        <= LAST_IDX;
    end else if (sdram_ready) begin
      sdram_request <= |grant;
      sdram_master  <= (|grant) ? grant_id : ID_W'(IDLE_ID);
      if (|grant) begin
        last_q <= grant_idx;
      end
    end
  end

  // Payload is don't-care while idle, so it only loads on a grant.
  always_ff @(posedge clock) begin
    if (!reset && sdram_ready && (|grant)) begin
      sdram_write   <= pick_write;
      sdram_burst   <= pick_burst;
      sdram_address <= pick_address;
      sdram_wdata   <= pick_wdata;
      sdram_byte_en <= pick_byte_en;
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < int'(NUM_MASTERS); k++) begin
      if (reset || !m_request[k] || (sdram_ready && grant[k])) begin
        wait_q[k] <= '0;
      end else if (sdram_ready && (wait_q[k] != CNT_W'(STARVE_LIMIT))) begin
        wait_q[k] <= wait_q[k] + CNT_W'(1);
      end
    end
  end

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_route
    assign m_valid[k]    = (sdram_valid == ID_W'(k + 1));
    assign m_complete[k] = (sdram_complete == ID_W'(k + 1));
  end

  assign m_rdata = (|m_valid) ? sdram_rdata : 32'h0;

endmodule
